// File: rtl/reset_sequencer_pkg.sv
// Shared state encodings for the reset sequencer FSM.
// Plain 2-bit constants so the State output maps directly onto debug LEDs.
package reset_seq_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage : reset_seq_pkg

// File: rtl/reset_sequencer_if.sv
// Request inputs and per-domain reset outputs of the reset sequencer.
// The board side drives the requests; the sequencer drives everything else.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);

  logic                  BTNS;
  logic                  SoftReset;
  logic [NUM_STAGES-1:0] Reset;
  logic                  Done;
  logic [1:0]            State;

  modport master (
    output BTNS,
    output SoftReset,
    input  Reset,
    input  Done,
    input  State
  );

  modport slave (
    input  BTNS,
    input  SoftReset,
    output Reset,
    output Done,
    output State
  );

endinterface : reset_sequencer_if

// File: rtl/reset_sequencer_sync.sv
// Generic flop-chain synchroniser for a single asynchronous board input.
// The reset value is a parameter so a button can come out of reset "pressed".
module bit_synchroniser #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {DEPTH{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule : bit_synchroniser

// File: rtl/reset_sequencer.sv
// Power-on/button reset generator: waits 2^COUNT_WIDTH cycles after the last
// request, then releases NUM_STAGES reset domains in order, GAP_CYCLES apart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int COUNT_WIDTH = 23,
  parameter int NUM_STAGES  = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              nReset,
  reset_sequencer_if.slave  bus
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int SW = $clog2(NUM_STAGES + 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);

  logic btn;
  logic req;

  logic [1:0]             state_q,  state_d;
  logic [COUNT_WIDTH-1:0] count_q,  count_d;
  logic [GW-1:0]          gap_q,    gap_d;
  logic [SW-1:0]          stage_q,  stage_d;
  logic [NUM_STAGES-1:0]  reset_q,  reset_d;
  logic                   done_q,   done_d;

  // Out of reset the synchroniser reads "pressed", so the button must be seen
  // released before the delay can start.
  bit_synchroniser #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_btn_sync (
    .clk   (Clk),
    .rst_n (nReset),
    .d_i   (bus.BTNS),
    .q_o   (btn)
  );

  assign req = btn | bus.SoftReset;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    count_d = count_q;
    gap_d   = gap_q;
    stage_d = stage_q;
    reset_d = reset_q;
    done_d  = done_q;

    if (req) begin
      state_d = ST_HOLD;
      count_d = '0;
      gap_d   = '0;
      stage_d = '0;
      reset_d = '1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_COUNT;
          count_d = '0;
        end
        ST_COUNT: begin
          // Count stops at all-ones; the edge that sees it frees domain 0.
          if (&count_q) begin
            reset_d[0] = 1'b0;
            stage_d    = SW'(1);
            gap_d      = '0;
            if (NUM_STAGES == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            count_d = count_q + COUNT_WIDTH'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (stage_q == SW'(i)) reset_d[i] = 1'b0;
            end
            gap_d   = '0;
            stage_d = stage_q + SW'(1);
            if (stage_q == STAGE_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: begin
          reset_d = '0;
          done_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_HOLD;
      count_q <= '0;
      gap_q   <= '0;
      stage_q <= '0;
      reset_q <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      stage_q <= stage_d;
      reset_q <= reset_d;
      done_q  <= done_d;
    end
  end

  assign bus.Reset = reset_q;
  assign bus.Done  = done_q;
  assign bus.State = state_q;

endmodule : reset_sequencer

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-domain build exercising every restart
// path, plus a 1-domain build that goes straight from COUNT to DONE.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int PROF = 22;

  logic clk = 1'b0;
  logic n_reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [2:0] cap_rst   [1:PROF];
  logic       cap_done  [1:PROF];
  logic [1:0] cap_state [1:PROF];

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(3)) bus3 ();
  reset_sequencer_if #(.NUM_STAGES(1)) bus1 ();

  reset_sequencer #(
    .COUNT_WIDTH (4), .NUM_STAGES (3), .GAP_CYCLES (2), .SYNC_STAGES (2)
  ) dut (
    .Clk (clk), .nReset (n_reset), .bus (bus3)
  );

  reset_sequencer #(
    .COUNT_WIDTH (4), .NUM_STAGES (1), .GAP_CYCLES (2), .SYNC_STAGES (2)
  ) dut1 (
    .Clk (clk), .nReset (n_reset), .bus (bus1)
  );

  // Expected {Reset, Done, State} k edges after HOLD->COUNT for the 3-domain build:
  // delay 16, then 2-cycle gaps.
  function automatic logic [5:0] exp3(input int k);
    if (k < 16)      return {3'b111, 1'b0, ST_COUNT};
    else if (k < 18) return {3'b110, 1'b0, ST_RELEASE};
    else if (k < 20) return {3'b100, 1'b0, ST_RELEASE};
    else             return {3'b000, 1'b1, ST_DONE};
  endfunction

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_rst[k]   = bus3.Reset;
      cap_done[k]  = bus3.Done;
      cap_state[k] = bus3.State;
    end
  endtask

  // Monotonic-release / no-glitch / Done-consistency monitor.
  logic [2:0] prev_rst;
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!n_reset) begin
      prev_valid = 1'b0;
    end else begin
      logic [2:0] m;
      m = ~bus3.Reset;
      n_checks++;
      if ((m & (m + 3'd1)) !== 3'b000 || bus3.Done !== (bus3.Reset == 3'b000))
        $display("FAIL monotonic: Reset=%b Done=%b", bus3.Reset, bus3.Done);
      else n_pass++;
      if (prev_valid) begin
        n_checks++;
        if ((bus3.Reset & ~prev_rst) != 3'b000 &&
            !(bus3.Reset == 3'b111 && bus3.State == ST_HOLD))
          $display("FAIL glitch: Reset %b -> %b State=%0d", prev_rst, bus3.Reset, bus3.State);
        else n_pass++;
      end
      prev_rst   = bus3.Reset;
      prev_valid = 1'b1;
    end
  end

  task automatic test_reset();
    n_reset = 1'b1;
    bus3.BTNS = 1'b0; bus3.SoftReset = 1'b0;
    bus1.BTNS = 1'b0; bus1.SoftReset = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    n_checks++;
    if ({bus3.Reset, bus3.Done, bus3.State} !== {3'b111, 1'b0, ST_HOLD})
      $display("FAIL por_async: got %b want %b", {bus3.Reset, bus3.Done, bus3.State}, {3'b111, 1'b0, ST_HOLD});
    else n_pass++;
    n_checks++;
    if ({bus1.Reset, bus1.Done, bus1.State} !== {1'b1, 1'b0, ST_HOLD})
      $display("FAIL por_async_1: got %b want %b", {bus1.Reset, bus1.Done, bus1.State}, {1'b1, 1'b0, ST_HOLD});
    else n_pass++;
    // Leave reset, run into COUNT, then pull nReset mid-cycle.
    @(negedge clk); #1 n_reset = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus3.State !== ST_COUNT) $display("FAIL pre_midrun: State got %0d want %0d", bus3.State, ST_COUNT);
    else n_pass++;
    #2 n_reset = 1'b0;
    #1;
    n_checks++;
    if ({bus3.Reset, bus3.Done, bus3.State} !== {3'b111, 1'b0, ST_HOLD})
      $display("FAIL midrun_async: got %b want %b", {bus3.Reset, bus3.Done, bus3.State}, {3'b111, 1'b0, ST_HOLD});
    else n_pass++;
    @(negedge clk); #1 n_reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus3.State !== ST_HOLD) $display("FAIL por_sync_hold: State got %0d want %0d", bus3.State, ST_HOLD);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus3.State !== ST_COUNT) $display("FAIL por_t0: State got %0d want %0d", bus3.State, ST_COUNT);
    else n_pass++;
    capture(PROF);
    for (int k = 1; k <= PROF; k++) begin
      n_checks++;
      if ({cap_rst[k], cap_done[k], cap_state[k]} !== exp3(k))
        $display("FAIL por_profile k=%0d: got %b want %b", k, {cap_rst[k], cap_done[k], cap_state[k]}, exp3(k));
      else n_pass++;
    end
  endtask

  task automatic test_button_restart();
    bus3.BTNS = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus3.Reset !== 3'b000) $display("FAIL btn_latency: Reset got %b want %b", bus3.Reset, 3'b000);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus3.Reset, bus3.Done, bus3.State} !== {3'b111, 1'b0, ST_HOLD})
      $display("FAIL btn_assert: got %b want %b", {bus3.Reset, bus3.Done, bus3.State}, {3'b111, 1'b0, ST_HOLD});
    else n_pass++;
    repeat (7) @(negedge clk);
    bus3.BTNS = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus3.State !== ST_HOLD) $display("FAIL btn_hold: State got %0d want %0d", bus3.State, ST_HOLD);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus3.State !== ST_COUNT) $display("FAIL btn_t0: State got %0d want %0d", bus3.State, ST_COUNT);
    else n_pass++;
    capture(PROF);
    for (int k = 1; k <= PROF; k++) begin
      n_checks++;
      if ({cap_rst[k], cap_done[k], cap_state[k]} !== exp3(k))
        $display("FAIL btn_profile k=%0d: got %b want %b", k, {cap_rst[k], cap_done[k], cap_state[k]}, exp3(k));
      else n_pass++;
    end
  endtask

  task automatic test_soft_reset();
    bus3.SoftReset = 1'b1;
    @(negedge clk);
    bus3.SoftReset = 1'b0;
    n_checks++;
    if ({bus3.Reset, bus3.Done, bus3.State} !== {3'b111, 1'b0, ST_HOLD})
      $display("FAIL soft_assert: got %b want %b", {bus3.Reset, bus3.Done, bus3.State}, {3'b111, 1'b0, ST_HOLD});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus3.State !== ST_COUNT) $display("FAIL soft_t0: State got %0d want %0d", bus3.State, ST_COUNT);
    else n_pass++;
    capture(PROF);
    for (int k = 1; k <= PROF; k++) begin
      n_checks++;
      if ({cap_rst[k], cap_done[k], cap_state[k]} !== exp3(k))
        $display("FAIL soft_profile k=%0d: got %b want %b", k, {cap_rst[k], cap_done[k], cap_state[k]}, exp3(k));
      else n_pass++;
    end
  endtask

  task automatic test_repress_release();
    bus3.SoftReset = 1'b1;
    @(negedge clk);
    bus3.SoftReset = 1'b0;
    @(negedge clk);
    capture(16);
    bus3.BTNS = 1'b1;
    @(negedge clk);
    bus3.BTNS = 1'b0;
    n_checks++;
    if (bus3.Reset !== 3'b110) $display("FAIL repress_k17: Reset got %b want %b", bus3.Reset, 3'b110);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus3.Reset, bus3.State} !== {3'b100, ST_RELEASE})
      $display("FAIL repress_k18: got %b want %b", {bus3.Reset, bus3.State}, {3'b100, ST_RELEASE});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus3.Reset, bus3.Done, bus3.State} !== {3'b111, 1'b0, ST_HOLD})
      $display("FAIL repress_assert: got %b want %b", {bus3.Reset, bus3.Done, bus3.State}, {3'b111, 1'b0, ST_HOLD});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus3.State !== ST_COUNT) $display("FAIL repress_t0: State got %0d want %0d", bus3.State, ST_COUNT);
    else n_pass++;
    capture(PROF);
    for (int k = 1; k <= PROF; k++) begin
      n_checks++;
      if ({cap_rst[k], cap_done[k], cap_state[k]} !== exp3(k))
        $display("FAIL repress_profile k=%0d: got %b want %b", k, {cap_rst[k], cap_done[k], cap_state[k]}, exp3(k));
      else n_pass++;
    end
  endtask

  task automatic test_press_in_count();
    bus3.SoftReset = 1'b1;
    @(negedge clk);
    bus3.SoftReset = 1'b0;
    @(negedge clk);
    capture(9);
    bus3.BTNS = 1'b1;
    @(negedge clk);
    bus3.BTNS = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus3.Reset, bus3.State} !== {3'b111, ST_COUNT})
      $display("FAIL count_k11: got %b want %b", {bus3.Reset, bus3.State}, {3'b111, ST_COUNT});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus3.Reset, bus3.Done, bus3.State} !== {3'b111, 1'b0, ST_HOLD})
      $display("FAIL count_assert: got %b want %b", {bus3.Reset, bus3.Done, bus3.State}, {3'b111, 1'b0, ST_HOLD});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus3.State !== ST_COUNT) $display("FAIL count_t0: State got %0d want %0d", bus3.State, ST_COUNT);
    else n_pass++;
    capture(PROF);
    for (int k = 1; k <= PROF; k++) begin
      n_checks++;
      if ({cap_rst[k], cap_done[k], cap_state[k]} !== exp3(k))
        $display("FAIL count_profile k=%0d: got %b want %b", k, {cap_rst[k], cap_done[k], cap_state[k]}, exp3(k));
      else n_pass++;
    end
  endtask

  task automatic test_single_stage();
    logic [3:0] want;
    bus1.SoftReset = 1'b1;
    @(negedge clk);
    bus1.SoftReset = 1'b0;
    n_checks++;
    if ({bus1.Reset, bus1.Done, bus1.State} !== {1'b1, 1'b0, ST_HOLD})
      $display("FAIL ns1_assert: got %b want %b", {bus1.Reset, bus1.Done, bus1.State}, {1'b1, 1'b0, ST_HOLD});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus1.State !== ST_COUNT) $display("FAIL ns1_t0: State got %0d want %0d", bus1.State, ST_COUNT);
    else n_pass++;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      want = (k < 16) ? {1'b1, 1'b0, ST_COUNT} : {1'b0, 1'b1, ST_DONE};
      n_checks++;
      if ({bus1.Reset, bus1.Done, bus1.State} !== want)
        $display("FAIL ns1_profile k=%0d: got %b want %b", k, {bus1.Reset, bus1.Done, bus1.State}, want);
      else n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_button_restart();
    test_soft_reset();
    test_repress_release();
    test_press_in_count();
    test_single_stage();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reset_sequencer
